// File: rtl/dll_replay_buffer.sv
// Data-link-layer replay buffer: numbers outgoing TLP words, sends them in order, retires them on ACK
// and replays unacknowledged words on NAK/timeout. Define REPLAY_BUFFER_PARITY_EN for per-entry parity.
module dll_replay_buffer #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 1024,
    parameter int SEQ_W      = 12,
    parameter int REPLAY_MAX = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [SEQ_W-1:0]       next_seq,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [DATA_W-1:0]      tx_data,
    output logic [SEQ_W-1:0]       tx_seq,
    input  logic                   ack_valid,
    input  logic                   ack_nak,
    input  logic [SEQ_W-1:0]       ack_seq,
    input  logic                   timeout,
    output logic                   replay_active,
    output logic                   retrain_req,
    output logic                   ack_err,
    output logic [$clog2(DEPTH):0] used,
    output logic                   mem_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int AW = PW + 1;
    localparam int CW = $clog2(REPLAY_MAX + 1);

    typedef enum logic {NORMAL, REPLAY} state_t;

    state_t            state, state_next;
    logic [AW-1:0]     head, send, tail, replay_end;
    logic [AW-1:0]     ld_ptr, inflight, head_new;
    logic [SEQ_W-1:0]  head_seq, ack_d, ack_back;
    logic [CW-1:0]     replay_cnt, cnt_base, cnt_inc;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [SEQ_W-1:0]  rd_seq;
    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [SEQ_W-1:0]  mem_seq  [DEPTH];
    logic wr_fire, ack_hit, ack_stale, replay_req, replay_go;
    logic out_load, issue, replay_done, retrain_hit;

    assign used      = tail - head;
    assign wr_ready  = (used != AW'(DEPTH));
    assign wr_fire   = wr_valid && wr_ready;
    // ld_ptr excludes a word still sitting in the read stage: only loaded words count as in flight.
    assign ld_ptr    = send - AW'(rd_valid);
    assign inflight  = ld_ptr - head;
    assign head_seq  = next_seq - SEQ_W'(used);
    assign ack_d     = ack_seq - head_seq;
    assign ack_back  = head_seq - ack_seq;
    assign ack_hit   = ack_valid && (ack_d < SEQ_W'(inflight));
    assign ack_stale = (ack_back != '0) && (ack_back <= SEQ_W'(DEPTH));
    assign head_new  = ack_hit ? head + AW'(ack_d) + AW'(1) : head;

    assign replay_req  = timeout || (ack_valid && ack_nak);
    assign replay_go   = replay_req && (head_new != ld_ptr);
    assign cnt_base    = ack_hit ? '0 : replay_cnt;
    assign cnt_inc     = cnt_base + CW'(1);
    assign retrain_hit = replay_go && (cnt_inc == CW'(REPLAY_MAX));

    assign out_load    = rd_valid && (!tx_valid || tx_ready);
    assign issue       = (send != tail) && (!rd_valid || out_load);
    assign replay_done = out_load && ((ld_ptr + AW'(1)) == replay_end);
    assign replay_active = (state == REPLAY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= NORMAL;
        else          state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            NORMAL: if (replay_go) state_next = REPLAY;
            REPLAY: begin
                if (replay_go)        state_next = REPLAY;
                else if (replay_done) state_next = NORMAL;
            end
        endcase
    end

    // NOTE: the entry store has no reset; the pointers alone decide which entries hold valid words.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_data[tail[PW-1:0]] <= wr_data;
            mem_seq[tail[PW-1:0]]  <= next_seq;
        end
        if (issue) begin
            rd_data <= mem_data[send[PW-1:0]];
            rd_seq  <= mem_seq[send[PW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head        <= '0;
            send        <= '0;
            tail        <= '0;
            replay_end  <= '0;
            next_seq    <= '0;
            replay_cnt  <= '0;
            rd_valid    <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            tx_seq      <= '0;
            retrain_req <= 1'b0;
            ack_err     <= 1'b0;
        end else begin
            retrain_req <= retrain_hit;
            ack_err     <= ack_valid && !ack_hit && !ack_stale;
            head        <= head_new;
            if (wr_fire) begin
                tail     <= tail + AW'(1);
                next_seq <= next_seq + SEQ_W'(1);
            end
            if (replay_go) begin
                // Flush both stages and rewind to the oldest unacknowledged entry.
                replay_end <= ld_ptr;
                send       <= head_new;
                rd_valid   <= 1'b0;
                tx_valid   <= 1'b0;
                replay_cnt <= retrain_hit ? '0 : cnt_inc;
            end else begin
                replay_cnt <= cnt_base;
                if (issue) send <= send + AW'(1);
                if (issue)         rd_valid <= 1'b1;
                else if (out_load) rd_valid <= 1'b0;
                if (out_load) begin
                    tx_valid <= 1'b1;
                    tx_data  <= rd_data;
                    tx_seq   <= rd_seq;
                end else if (tx_ready) begin
                    tx_valid <= 1'b0;
                end
            end
        end
    end

`ifdef REPLAY_BUFFER_PARITY_EN
    logic mem_par [DEPTH];
    logic rd_par;

    always_ff @(posedge clk) begin
        if (wr_fire) mem_par[tail[PW-1:0]] <= ^{wr_data, next_seq};
        if (issue)   rd_par <= mem_par[send[PW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mem_err <= 1'b0;
        else if (out_load && !replay_go && (^{rd_data, rd_seq, rd_par}))
            mem_err <= 1'b1;
    end
`else
    assign mem_err = 1'b0;
`endif

endmodule

// File: doc/dll_replay_buffer.md
# dll_replay_buffer

Parametrised data-link-layer replay buffer between the transaction-layer TLP source and the link transmitter. It stores every outgoing TLP with an auto-assigned sequence number and transmits in order. Entries are retired on ACK. The buffer replays all unacknowledged transmitted entries on NAK or replay timeout, and raises a retrain request after REPLAY_MAX consecutive replays without forward progress.

## Interface
- DATA_W, 64, TLP word width
- DEPTH, 1024, entry count; power of two, at most 2^(SEQ_W-1)
- SEQ_W, 12, sequence number width
- REPLAY_MAX, 4, consecutive replays before retrain_req
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  source presents a TLP word
- wr_ready  out  1  entry free; combinational from registered pointers
- wr_data  in  DATA_W  TLP word
- next_seq  out  SEQ_W  sequence number the next accepted word will get
- tx_valid  out  1  output word valid
- tx_ready  in  1  transmitter accepts
- tx_data  out  DATA_W  transmitted word
- tx_seq  out  SEQ_W  sequence number of tx_data
- ack_valid  in  1  DLLP received, one-cycle pulse
- ack_nak  in  1  0 = ACK, 1 = NAK
- ack_seq  in  SEQ_W  AckNak_Seq_Num
- timeout  in  1  replay timer expired, one-cycle pulse
- replay_active  out  1  high while replaying
- retrain_req  out  1  one-cycle pulse on replay-count rollover
- ack_err  out  1  one-cycle pulse: ack_seq outside in-flight window
- used  out  log2(DEPTH)+1  occupied entries
- mem_err  out  1  sticky parity error (see Configuration)

## Operation
- Three pointers, each log2(DEPTH)+1 bits with a wrap bit:
  - head: oldest unacked entry.
  - send: next entry to read.
  - tail: next free entry.
- Per-entry storage holds the data word and its seq.
- Write:
  - Accepted when wr_valid && wr_ready, with wr_ready = (used != DEPTH).
  - The word is stored at tail with seq = next_seq.
  - tail and next_seq both increment. next_seq wraps modulo 2^SEQ_W.
  - Writes are accepted in every state.
- In-flight window: entries head..send-1, which have been loaded to the output stage.
- ACK/NAK purge:
  - d = (ack_seq - seq[head]) mod 2^SEQ_W.
  - If d < inflight: head += d+1, and the replay counter clears.
  - Else: no purge; ack_err pulses if d is not within the DEPTH entries below seq[head] (duplicate/stale ACKs are silent).
- NAK: purge as above, then start replay.
- timeout: start replay, no purge.
- Replay start:
  - If head == send after purge: no replay, counter unchanged.
  - Else:
    - replay_end = send; send = head; the output register is flushed; state = REPLAY.
    - The replay counter increments. If it reaches REPLAY_MAX, retrain_req pulses and the counter returns to 0.
- States:
  - NORMAL → REPLAY on replay start.
  - REPLAY → NORMAL when the word at replay_end-1 is loaded to the output stage.
  - A NAK or timeout during REPLAY restarts the replay from the current head.
- Simultaneous events:
  - ack_valid and timeout in the same cycle: purge first, then replay from the new head.
  - Write plus purge in the same cycle: both applied; used reflects both.
- Output stage: one register. It loads from memory when empty or being accepted and send != tail.
- tx_valid deasserts without handshake only on a replay-start flush.

## Timing
- Reset values (all registered outputs and state):
  - tx_valid=0, tx_data=0, tx_seq=0.
  - replay_active=0, retrain_req=0, ack_err=0, mem_err=0.
  - next_seq=0, used=0, wr_ready=1.
  - Pointers and counter 0, state NORMAL.
- Reset mid-operation discards all entries immediately.
- Latency from write accept at edge N to tx_valid is edge N+2, via synchronous memory read.
- Sustained throughput is 1 word/cycle with tx_ready high.
- An ACK at edge N updates used and wr_ready from edge N+1.
- A NAK or timeout at edge N:
  - tx_valid=0 and replay_active=1 after edge N.
  - The first replayed word is valid after edge N+2.

## Configuration
- REPLAY_BUFFER_PARITY_EN:
  - Defined: each entry stores an even-parity bit over data and seq, which is checked at output load. A mismatch sets mem_err, sticky until reset; data still passes.
  - Undefined: no parity storage; mem_err tied 0.

## Test plan
- Write 3 words (seqs 0,1,2), tx_ready=1 → tx words in order with tx_seq 0,1,2 at cycles 2,3,4; used=3.
- After that, ACK seq 1 → used=1, head seq=2; duplicate ACK seq 1 → no change, ack_err=0; ACK seq 100 → ack_err pulse.
- Transmit seqs 0..4, then NAK seq 1 → used=3, replay_active=1, tx_seq 2,3,4 resent, then return to NORMAL and new writes continue at seq 5.
- Fill DEPTH entries → wr_ready=0; ACK the last seq → used=0, wr_ready=1; next_seq wraps 4095→0 across repeated fills.
- 4 consecutive timeouts with no ACK (REPLAY_MAX=4) → retrain_req pulses once on the 4th; an ACK purging ≥1 entry between timeouts prevents it.
- timeout coincident with ACK seq 0 over seqs 0..2 → replay begins at seq 1; reset_n low mid-replay → all outputs return to reset values next cycle.
